// File: rtl/filter.sv
// filter: streaming 5-tap FIR with a registered low-pass output and a
// complementary high-pass output (centre sample minus low-pass).
// Pipeline: delay line -> registered products + centre sample -> registered outputs.
module filter #(
   parameter logic signed [15:0] C0 = 16'sd2048,
   parameter logic signed [15:0] C1 = 16'sd8192,
   parameter logic signed [15:0] C2 = 16'sd12288,
   parameter logic signed [15:0] C3 = 16'sd8192,
   parameter logic signed [15:0] C4 = 16'sd2048
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] xn,
   output logic [31:0] low_pass,
   output logic [31:0] high_pass
);

   logic signed [31:0] d_q [5];
   logic signed [31:0] d_d [5];
   logic signed [47:0] p_q [5];
   logic signed [47:0] p_d [5];
   logic signed [31:0] c_q, c_d;
   logic signed [31:0] lp_q, lp_d;
   logic signed [31:0] hp_q, hp_d;
   logic signed [50:0] acc;
   logic signed [50:0] scaled;
   logic signed [32:0] diff;

   // Full-precision signed 32x16 product; the true result always fits 48 bits.
   function automatic logic signed [47:0] mul48(input logic signed [31:0] a,
                                                input logic signed [15:0] b);
      return $signed({{16{a[31]}}, a}) * $signed({{32{b[15]}}, b});
   endfunction

   // Delay line shift, tap products and the centre sample aligned with them.
   always_comb begin
      d_d[0] = xn;
      for (int k = 1; k < 5; k++) d_d[k] = d_q[k-1];
      p_d[0] = mul48(d_q[0], C0);
      p_d[1] = mul48(d_q[1], C1);
      p_d[2] = mul48(d_q[2], C2);
      p_d[3] = mul48(d_q[3], C3);
      p_d[4] = mul48(d_q[4], C4);
      c_d    = d_q[2];
   end

   // Sum products, scale to Q15.16 by flooring shift, saturate, then derive high-pass.
   always_comb begin
      acc = '0;
      for (int k = 0; k < 5; k++) acc = acc + {{3{p_q[k][47]}}, p_q[k]};
      scaled = acc >>> 15;
      if (scaled[50:31] == {20{1'b0}} || scaled[50:31] == {20{1'b1}})
         lp_d = scaled[31:0];
      else
         lp_d = scaled[50] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
      diff = {c_q[31], c_q} - {lp_d[31], lp_d};
      if (diff[32] != diff[31])
         hp_d = diff[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
      else
         hp_d = diff[31:0];
   end

   // Pipeline registers; reset discards all history and zeroes the outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 5; k++) begin
            d_q[k] <= '0;
            p_q[k] <= '0;
         end
         c_q  <= '0;
         lp_q <= '0;
         hp_q <= '0;
      end else begin
         for (int k = 0; k < 5; k++) begin
            d_q[k] <= d_d[k];
            p_q[k] <= p_d[k];
         end
         c_q  <= c_d;
         lp_q <= lp_d;
         hp_q <= hp_d;
      end
   end

   assign low_pass  = lp_q;
   assign high_pass = hp_q;

endmodule

// File: tb/tb_filter.sv
// tb_filter: directed and random stimulus on two filter instances (default
// coefficients and all-0.5 coefficients), checked against a windowed-sum model.
module tb_filter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] xn  = '0;
   logic [31:0] lp_def, hp_def, lp_sat, hp_sat;

   int checks   = 0;
   int failures = 0;
   int n_edge   = -1;
   int last_rst = -100;
   longint hist [4096];
   longint cdef [5] = '{2048, 8192, 12288, 8192, 2048};
   longint csat [5] = '{16384, 16384, 16384, 16384, 16384};
   logic [31:0] imp_lp [6] = '{32'h00001000, 32'h00004000, 32'h00006000,
                               32'h00004000, 32'h00001000, 32'h00000000};
   logic [31:0] imp_hp [6] = '{32'hFFFFF000, 32'hFFFFC000, 32'h0000A000,
                               32'hFFFFC000, 32'hFFFFF000, 32'h00000000};

   filter u_def (.clk(clk), .rst(rst), .xn(xn), .low_pass(lp_def), .high_pass(hp_def));

   filter #(.C0(16'sd16384), .C1(16'sd16384), .C2(16'sd16384),
            .C3(16'sd16384), .C4(16'sd16384))
      u_sat (.clk(clk), .rst(rst), .xn(xn), .low_pass(lp_sat), .high_pass(hp_sat));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Output after edge n: 5-sample window ending two edges earlier, with any
   // sample taken at or before the latest reset treated as zero.
   function automatic void model(input int n, input longint c [5],
                                 output logic [31:0] lp, output logic [31:0] hp);
      longint x [5];
      longint acc, lv, hv;
      int idx;
      acc = 0;
      for (int j = 0; j < 5; j++) begin
         idx  = n - 2 - j;
         x[j] = (idx < 0 || idx <= last_rst) ? 0 : hist[idx];
         acc += x[j] * c[j];
      end
      lv = acc >>> 15;
      if (lv > 64'sd2147483647)  lv = 64'sd2147483647;
      if (lv < -64'sd2147483648) lv = -64'sd2147483648;
      hv = x[2] - lv;
      if (hv > 64'sd2147483647)  hv = 64'sd2147483647;
      if (hv < -64'sd2147483648) hv = -64'sd2147483648;
      if (last_rst >= n - 1) begin
         lv = 0;
         hv = 0;
      end
      lp = lv[31:0];
      hp = hv[31:0];
   endfunction

   task automatic step(input logic [31:0] x, input logic r);
      logic [31:0] elp, ehp;
      xn  = x;
      rst = r;
      @(posedge clk);
      n_edge++;
      hist[n_edge] = longint'($signed(x));
      if (r) last_rst = n_edge;
      #1;
      model(n_edge, cdef, elp, ehp);
      chk("def_lp", lp_def, elp);
      chk("def_hp", hp_def, ehp);
      model(n_edge, csat, elp, ehp);
      chk("sat_lp", lp_sat, elp);
      chk("sat_hp", hp_sat, ehp);
   endtask

   task automatic impulse();
      step(32'h0001_0000, 1'b0);
      step(32'h0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         step(32'h0, 1'b0);
         chk("imp_lp", lp_def, imp_lp[i]);
         chk("imp_hp", hp_def, imp_hp[i]);
      end
   endtask

   initial begin
      logic [31:0] v;
      // reset held for two edges with a non-zero input
      for (int i = 0; i < 2; i++) begin
         step(32'h1234_5678, 1'b1);
         chk("rst_lp", lp_def, 32'h0);
         chk("rst_hp", hp_def, 32'h0);
      end
      for (int i = 0; i < 3; i++) step(32'h0, 1'b0);

      impulse();

      // DC step: unity gain low-pass, zero high-pass once the window fills
      for (int i = 0; i < 10; i++) begin
         step(32'h0002_0000, 1'b0);
         if (i >= 6) begin
            chk("dc_lp", lp_def, 32'h0002_0000);
            chk("dc_hp", hp_def, 32'h0);
         end
      end

      // mid-stream reset then impulse: no DC residue allowed
      step(32'h0002_0000, 1'b1);
      chk("mrst_lp", lp_def, 32'h0);
      chk("mrst_hp", hp_def, 32'h0);
      impulse();

      // Nyquist: low-pass nulls, high-pass is the input 4 edges late
      for (int i = 0; i < 20; i++) begin
         step((i % 2 == 0) ? 32'h4000_0000 : 32'hC000_0000, 1'b0);
         if (i >= 6) begin
            chk("nyq_lp", lp_def, 32'h0);
            chk("nyq_hp", hp_def, ((i - 4) % 2 == 0) ? 32'h4000_0000 : 32'hC000_0000);
         end
      end

      // saturation with gain 2.5
      for (int i = 0; i < 10; i++) begin
         step(32'h7FFF_FFFF, 1'b0);
         if (i >= 6) begin
            chk("satp_lp", lp_sat, 32'h7FFF_FFFF);
            chk("satp_hp", hp_sat, 32'h0);
         end
      end
      for (int i = 0; i < 10; i++) begin
         step(32'h8000_0000, 1'b0);
         if (i >= 6) begin
            chk("satn_lp", lp_sat, 32'h8000_0000);
            chk("satn_hp", hp_sat, 32'h0);
         end
      end

      // random mix: full-range, small, extreme values and occasional resets
      for (int i = 0; i < 1500; i++) begin
         case ($urandom_range(0, 3))
            0: v = $urandom;
            1: v = $urandom_range(0, 32'h0004_0000) - 32'h0002_0000;
            2: v = ($urandom_range(0, 1) == 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
            default: v = {{4{$urandom_range(0, 1) == 1}}, 28'($urandom)};
         endcase
         step(v, $urandom_range(0, 49) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
